// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide, one step per clock.
// Define MULTDIV_DIV0_FAST_EN to finish a divide-by-zero one edge after start.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_reg;
    logic [CW-1:0]      count_reg;
    logic               is_div_reg;
    logic               neg_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   opnd_reg;
    // mult: {partial product high, multiplier}; div: {remainder, quotient/dividend}
    logic [2*WIDTH:0]   acc_reg;

    logic               start;
    logic               start_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH:0]   step_next;

    always_comb begin
        mul_sum   = acc_reg[2*WIDTH:WIDTH] + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next  = {1'b0, mul_sum, acc_reg[WIDTH-1:1]};
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        // True difference is below 2^WIDTH whenever div_ge holds.
        div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
        if (div_ge) begin
            div_next = {1'b0, div_diff, acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {1'b0, div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end
        step_next = is_div_reg ? div_next : mul_next;
    end

    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH:0]     ovf_bits;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    always_comb begin
        prod_signed = neg_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
        ovf_bits    = prod_signed[2*WIDTH-1:WIDTH-1];
        quot_signed = neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        fin_result  = '0;
        fin_exc     = 1'b0;
        if (!is_div_reg) begin
            fin_result = prod_signed[WIDTH-1:0];
            fin_exc    = ~((&ovf_bits) | ~(|ovf_bits));
        end else if (div0_reg) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            // Only a positive quotient of magnitude 2^(WIDTH-1) cannot be represented.
            fin_result = quot_signed;
            fin_exc    = ~neg_reg & acc_reg[WIDTH-1];
        end
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            is_div_reg     <= 1'b0;
            neg_reg        <= 1'b0;
            div0_reg       <= 1'b0;
            opnd_reg       <= '0;
            acc_reg        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_reg)
                RUN: begin
                    acc_reg   <= step_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    data_result    <= fin_result;
                    data_exception <= fin_exc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    count_reg      <= '0;
                    state_reg      <= IDLE;
                end
                default: ;
            endcase
            // A start wins over whatever the FSM was doing, including an abort mid-RUN.
            if (start) begin
                is_div_reg <= start_div;
                neg_reg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0_reg   <= start_div && (data_operandB == '0);
                opnd_reg   <= start_div ? abs_b : abs_a;
                acc_reg    <= {{(WIDTH+1){1'b0}}, (start_div ? abs_a : abs_b)};
                count_reg  <= '0;
                busy       <= 1'b1;
`ifdef MULTDIV_DIV0_FAST_EN
                state_reg  <= (start_div && (data_operandB == '0)) ? FINISH : RUN;
`else
                state_reg  <= RUN;
`endif
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected results queued at start, checked on each ready strobe.
module tb_multdiv_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;
`ifdef MULTDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = W + 1;
`endif
    localparam int OP_MUL  = 0;
    localparam int OP_DIV  = 1;
    localparam int OP_BOTH = 2;

    logic          clock;
    logic          clr;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    typedef struct {
        string      tag;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .clr            (clr),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input bit is_div, input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        longint              p;
        logic signed [31:0]  lo;
        logic signed [31:0]  q;
        if (!is_div) begin
            p  = longint'(a) * longint'(b);
            lo = p[31:0];
            return {(p != longint'(lo)), lo};
        end
        if (b == 0) return {1'b1, 32'h0};
        if (a == 32'sh8000_0000 && b == -32'sd1) return {1'b1, 32'h8000_0000};
        q = a / b;
        return {1'b0, q};
    endfunction

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (clr && data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_result"}, 64'(data_result), 64'(e.res));
                check({e.tag, "_exc"}, 64'(data_exception), 64'(e.exc));
            end
        end
    end

    // Call at a negedge; returns at the negedge after the start edge E0.
    task automatic start_op(input string tag, input int op, input logic [31:0] a,
                            input logic [31:0] b, input bit push);
        logic [32:0] m;
        exp_t        e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = (op != OP_DIV);
        ctrl_DIV      = (op != OP_MUL);
        if (push) begin
            m     = model(op == OP_DIV, a, b);
            e.tag = tag;
            e.res = m[31:0];
            e.exc = m[32];
            exp_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_rdy(input string tag, input int lat);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < lat + 5) begin
            @(negedge clock);
            n++;
            if (data_resultRDY) found = 1;
            else check({tag, "_busy_run"}, 64'(busy), 64'd1);
        end
        if (!found) begin
            check({tag, "_rdy_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(n), 64'(lat));
            check({tag, "_busy_at_rdy"}, 64'(busy), 64'd0);
            @(negedge clock);
            check({tag, "_rdy_width"}, 64'(data_resultRDY), 64'd0);
        end
    endtask

    task automatic run(input string tag, input int op, input logic [31:0] a,
                       input logic [31:0] b, input int lat);
        start_op(tag, op, a, b, 1'b1);
        wait_rdy(tag, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        clr = 1'b1;
        @(negedge clock);

        run("mul_7x-6", OP_MUL, 32'd7, -32'd6, LAT);
        run("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, LAT);
        run("div_-100/7", OP_DIV, -32'd100, 32'd7, LAT);
        run("div_min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT);
        run("div_by0", OP_DIV, 32'd5, 32'd0, DIV0_LAT);
        run("both_mul_wins", OP_BOTH, 32'd6, 32'd3, LAT);
        run("mul_min*-1", OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, LAT);
        run("mul_min*1", OP_MUL, 32'h8000_0000, 32'd1, LAT);
        run("div_7/-7", OP_DIV, 32'd7, -32'd7, LAT);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
            if (rb == 0) rb = 32'd3;
            run($sformatf("rnd%0d", i), (i % 2 == 0) ? OP_MUL : OP_DIV, ra, rb, LAT);
        end

        // Restart: multiply aborted by a divide at E10, no strobe for the multiply.
        start_op("restart_mul", OP_MUL, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clock);
        run("restart_div", OP_DIV, 32'd20, 32'd5, LAT);

        // Asynchronous reset at E15 of a multiply.
        start_op("rst_mul", OP_MUL, 32'd9, 32'd11, 1'b0);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2 clr = 1'b0;
        #1;
        check("midrst_result", 64'(data_result), 64'd0);
        check("midrst_exc", 64'(data_exception), 64'd0);
        check("midrst_rdy", 64'(data_resultRDY), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        clr = 1'b1;
        repeat (40) @(negedge clock);
        check("postrst_busy", 64'(busy), 64'd0);
        run("mul_2x3", OP_MUL, 32'd2, 32'd3, LAT);

        repeat (3) @(negedge clock);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
